// File: rtl/alu8_issue_pkg.sv
// Shared widths, instruction payload and FSM encoding for alu8_issue.
package alu8_issue_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned REG_AW   = 2;
  localparam int unsigned OP_W     = 3;
  localparam int unsigned NUM_REGS = 4;

  // Instruction fields captured at acceptance
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              imm_en;
    logic [DATA_W-1:0] imm;
  } inst_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

endpackage

// File: rtl/alu8_issue.sv
// alu8_issue: three-cycle issue/execute sequencer around an external 8-bit ALU.
// Accepts one instruction at a time (IDLE), reads its operands from a 4 x 8-bit
// register file into the ALU operand registers (FETCH), then writes the ALU
// result back to the register file and reports it on a one-cycle writeback
// pulse (EXEC).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instValid/instReady      instruction handshake
//   instOp/Rd/Rs/Rt/ImmEn/Imm instruction fields
//   aluFunSel/aluA/aluB      registered drive to the external ALU
//   aluResult/aluZero        combinational ALU return
//   wbValid/wbData/wbZero/wbRd/wbErr  writeback report
//   dbgAddr/dbgData          combinational register-file read port
module alu8_issue
  import alu8_issue_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instValid,
  output logic              instReady,
  input  logic [OP_W-1:0]   instOp,
  input  logic [REG_AW-1:0] instRd,
  input  logic [REG_AW-1:0] instRs,
  input  logic [REG_AW-1:0] instRt,
  input  logic              instImmEn,
  input  logic [DATA_W-1:0] instImm,
  output logic [OP_W-1:0]   aluFunSel,
  output logic [DATA_W-1:0] aluA,
  output logic [DATA_W-1:0] aluB,
  input  logic [DATA_W-1:0] aluResult,
  input  logic              aluZero,
  output logic              wbValid,
  output logic [DATA_W-1:0] wbData,
  output logic              wbZero,
  output logic [REG_AW-1:0] wbRd,
  output logic              wbErr,
  input  logic [REG_AW-1:0] dbgAddr,
  output logic [DATA_W-1:0] dbgData
);

  state_t            state_q, state_d;
  inst_t             inst_q, inst_d;
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];
  logic              ready_q, ready_d;
  logic [OP_W-1:0]   alu_fun_q, alu_fun_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_zero_q, wb_zero_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic              wb_err_q, wb_err_d;

  // State and datapath registers; reset overrides every FSM action
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      inst_q     <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= RESET_VAL;
      ready_q    <= 1'b1;
      alu_fun_q  <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_zero_q  <= 1'b0;
      wb_rd_q    <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      rf_q       <= rf_d;
      ready_q    <= ready_d;
      alu_fun_q  <= alu_fun_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_zero_q  <= wb_zero_d;
      wb_rd_q    <= wb_rd_d;
      wb_err_q   <= wb_err_d;
    end
  end

  // Next-state and next-output logic; everything holds unless the state acts
  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    rf_d       = rf_q;
    ready_d    = ready_q;
    alu_fun_d  = alu_fun_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_zero_d  = wb_zero_q;
    wb_rd_d    = wb_rd_q;
    wb_err_d   = wb_err_q;

    case (state_q)
      ST_IDLE: begin
        if (instValid && ready_q) begin
          inst_d.op     = instOp;
          inst_d.rd     = instRd;
          inst_d.rs     = instRs;
          inst_d.rt     = instRt;
          inst_d.imm_en = instImmEn;
          inst_d.imm    = instImm;
          ready_d       = 1'b0;
          state_d       = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Operands read here see the previous instruction's EXEC write
        alu_a_d   = rf_q[inst_q.rs];
        alu_b_d   = inst_q.imm_en ? inst_q.imm : rf_q[inst_q.rt];
        alu_fun_d = inst_q.op;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        rf_d[inst_q.rd] = aluResult;
        wb_valid_d      = 1'b1;
        wb_data_d       = aluResult;
        wb_zero_d       = aluZero;
        wb_rd_d         = inst_q.rd;
        wb_err_d        = inst_q.op inside {3'b100, 3'b101, 3'b110};
        ready_d         = 1'b1;
        state_d         = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign instReady = ready_q;
  assign aluFunSel = alu_fun_q;
  assign aluA      = alu_a_q;
  assign aluB      = alu_b_q;
  assign wbValid   = wb_valid_q;
  assign wbData    = wb_data_q;
  assign wbZero    = wb_zero_q;
  assign wbRd      = wb_rd_q;
  assign wbErr     = wb_err_q;
  assign dbgData   = rf_q[dbgAddr];

endmodule

// File: tb/tb_alu8_issue.sv
// tb_alu8_issue: self-checking bench for alu8_issue. Provides a behavioural
// 8-bit ALU on the ALU ports and checks writebacks against a register-file
// model updated in program order.
module tb_alu8_issue;

  logic       clk = 1'b0;
  logic       rst;
  logic       instValid;
  logic       instReady;
  logic [2:0] instOp;
  logic [1:0] instRd, instRs, instRt;
  logic       instImmEn;
  logic [7:0] instImm;
  logic [2:0] aluFunSel;
  logic [7:0] aluA, aluB, aluResult;
  logic       aluZero;
  logic       wbValid;
  logic [7:0] wbData;
  logic       wbZero;
  logic [1:0] wbRd;
  logic       wbErr;
  logic [1:0] dbgAddr;
  logic [7:0] dbgData;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] mrf [4];

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd, rs, rt;
    logic       ie;
    logic [7:0] imm;
    logic [7:0] ex;
  } vec_t;

  always #5 clk = ~clk;

  alu8_issue #(.RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst),
    .instValid(instValid), .instReady(instReady),
    .instOp(instOp), .instRd(instRd), .instRs(instRs), .instRt(instRt),
    .instImmEn(instImmEn), .instImm(instImm),
    .aluFunSel(aluFunSel), .aluA(aluA), .aluB(aluB),
    .aluResult(aluResult), .aluZero(aluZero),
    .wbValid(wbValid), .wbData(wbData), .wbZero(wbZero), .wbRd(wbRd), .wbErr(wbErr),
    .dbgAddr(dbgAddr), .dbgData(dbgData)
  );

  // External ALU stand-in
  always_comb begin
    case (aluFunSel)
      3'b000:  aluResult = aluA & aluB;
      3'b001:  aluResult = aluA | aluB;
      3'b010:  aluResult = aluA + aluB;
      3'b011:  aluResult = aluA - aluB;
      3'b111:  aluResult = {7'd0, aluA < aluB};
      default: aluResult = 8'h00;
    endcase
  end
  assign aluZero = (aluResult == 8'h00);

  // Reference result from the instruction-set rules in integer arithmetic
  function automatic logic [7:0] ref_alu(input logic [2:0] op, input int a, input int b);
    int r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = (a + b) % 256;
      3'd3:    r = (a - b + 256) % 256;
      3'd7:    r = (a < b) ? 1 : 0;
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  // Offer one instruction, return the writeback seen and the edge count to it
  task automatic run_inst(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                          input logic [1:0] rt, input logic ie, input logic [7:0] imm,
                          output logic [7:0] d, output logic z, output logic [1:0] r,
                          output logic e, output logic [7:0] dbg, output int lat);
    int n;
    n = 0; lat = -1; d = 'x; z = 'x; r = 'x; e = 'x; dbg = 'x;
    while (instReady !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (instReady !== 1'b1) return;
    instOp = op; instRd = rd; instRs = rs; instRt = rt; instImmEn = ie; instImm = imm;
    dbgAddr = rd; instValid = 1'b1;
    @(posedge clk); #1;
    instValid = 1'b0; lat = 1;
    while (wbValid !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
    d = wbData; z = wbZero; r = wbRd; e = wbErr; dbg = dbgData;
  endtask

  task automatic test_reset();
    rst = 1'b1; instValid = 1'b1; instOp = 3'd2; instRd = 2'd1; instRs = 2'd0; instRt = 2'd0;
    instImmEn = 1'b1; instImm = 8'h5A; dbgAddr = 2'd0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; instValid = 1'b0;
    n_checks++; if (instReady !== 1'b1) begin n_fail++; $display("FAIL reset instReady got %b exp 1", instReady); end
    n_checks++; if (wbValid !== 1'b0) begin n_fail++; $display("FAIL reset wbValid got %b exp 0", wbValid); end
    n_checks++; if ({aluFunSel, aluA, aluB} !== 19'd0) begin n_fail++; $display("FAIL reset alu regs got %h/%h/%h exp 0", aluFunSel, aluA, aluB); end
    n_checks++; if ({wbData, wbZero, wbRd, wbErr} !== 12'd0) begin n_fail++; $display("FAIL reset wb regs got %h/%b/%0d/%b exp 0", wbData, wbZero, wbRd, wbErr); end
    for (int a = 0; a < 4; a++) begin
      dbgAddr = 2'(a); #1;
      n_checks++; if (dbgData !== 8'h00) begin n_fail++; $display("FAIL reset reg[%0d] got %h exp 00", a, dbgData); end
      mrf[a] = 8'h00;
    end
  endtask

  task automatic test_directed(input string tag, input vec_t v[]);
    logic [7:0] d, dbg; logic z, e; logic [1:0] r; int lat;
    foreach (v[i]) begin
      run_inst(v[i].op, v[i].rd, v[i].rs, v[i].rt, v[i].ie, v[i].imm, d, z, r, e, dbg, lat);
      mrf[v[i].rd] = v[i].ex;
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL %s[%0d] latency got %0d exp 3", tag, i, lat); end
      n_checks++; if (d !== v[i].ex) begin n_fail++; $display("FAIL %s[%0d] wbData got %h exp %h", tag, i, d, v[i].ex); end
      n_checks++; if (z !== (v[i].ex == 8'h00)) begin n_fail++; $display("FAIL %s[%0d] wbZero got %b exp %b", tag, i, z, v[i].ex == 8'h00); end
      n_checks++; if (r !== v[i].rd) begin n_fail++; $display("FAIL %s[%0d] wbRd got %0d exp %0d", tag, i, r, v[i].rd); end
      n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL %s[%0d] wbErr got %b exp 0", tag, i, e); end
      n_checks++; if (dbg !== v[i].ex) begin n_fail++; $display("FAIL %s[%0d] dbgData got %h exp %h", tag, i, dbg, v[i].ex); end
    end
  endtask

  task automatic test_imm_add();
    vec_t v[];
    v = new[2];
    v[0] = '{3'd2, 2'd1, 2'd0, 2'd0, 1'b1, 8'hFF, 8'hFF};
    v[1] = '{3'd2, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01, 8'h00};
    test_directed("imm_add", v);
  endtask

  task automatic test_reg_ops();
    vec_t v[];
    v = new[6];
    v[0] = '{3'd2, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 8'h05};
    v[1] = '{3'd2, 2'd2, 2'd0, 2'd0, 1'b1, 8'h07, 8'h07};
    v[2] = '{3'd3, 2'd3, 2'd1, 2'd2, 1'b0, 8'hAA, 8'hFE};
    v[3] = '{3'd7, 2'd3, 2'd1, 2'd2, 1'b0, 8'hAA, 8'h01};
    v[4] = '{3'd0, 2'd3, 2'd1, 2'd2, 1'b0, 8'hAA, 8'h05};
    v[5] = '{3'd1, 2'd3, 2'd1, 2'd2, 1'b0, 8'hAA, 8'h07};
    test_directed("reg_ops", v);
  endtask

  task automatic test_back_to_back();
    int acc[$]; int cyc; int lat; logic wb_at_b; logic [7:0] wb_data_at_b; logic acc_now;
    cyc = 0; wb_at_b = 1'b0; wb_data_at_b = 8'h00;
    instOp = 3'd2; instRd = 2'd1; instRs = 2'd0; instRt = 2'd0; instImmEn = 1'b1; instImm = 8'h10;
    instValid = 1'b1;
    while (acc.size() < 2 && cyc < 20) begin
      acc_now = instValid && instReady;
      if (acc_now && acc.size() == 1) begin wb_at_b = wbValid; wb_data_at_b = wbData; end
      @(posedge clk); #1;
      if (acc_now) begin
        acc.push_back(cyc);
        if (acc.size() == 1) begin instRd = 2'd2; instRs = 2'd1; instRt = 2'd1; instImmEn = 1'b0; end
        else instValid = 1'b0;
      end
      cyc++;
    end
    instValid = 1'b0;
    mrf[1] = 8'h10; mrf[2] = 8'h20;
    n_checks++; if (acc.size() !== 2) begin n_fail++; $display("FAIL b2b accepts got %0d exp 2", acc.size()); end
    if (acc.size() == 2) begin
      n_checks++; if (acc[1] - acc[0] !== 3) begin n_fail++; $display("FAIL b2b accept spacing got %0d exp 3", acc[1] - acc[0]); end
    end
    n_checks++; if (wb_at_b !== 1'b1) begin n_fail++; $display("FAIL b2b wbValid at second accept got %b exp 1", wb_at_b); end
    n_checks++; if (wb_data_at_b !== 8'h10) begin n_fail++; $display("FAIL b2b first wbData got %h exp 10", wb_data_at_b); end
    lat = 1;
    while (wbValid !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL b2b second latency got %0d exp 3", lat); end
    n_checks++; if (wbData !== 8'h20) begin n_fail++; $display("FAIL b2b raw wbData got %h exp 20", wbData); end
    n_checks++; if (wbRd !== 2'd2) begin n_fail++; $display("FAIL b2b wbRd got %0d exp 2", wbRd); end
    dbgAddr = 2'd2; #1;
    n_checks++; if (dbgData !== 8'h20) begin n_fail++; $display("FAIL b2b reg[2] got %h exp 20", dbgData); end
  endtask

  task automatic test_reserved();
    logic [7:0] d, dbg; logic z, e; logic [1:0] r; int lat;
    run_inst(3'b101, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, d, z, r, e, dbg, lat);
    mrf[3] = 8'h00;
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL reserved latency got %0d exp 3", lat); end
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reserved wbData got %h exp 00", d); end
    n_checks++; if (z !== 1'b1) begin n_fail++; $display("FAIL reserved wbZero got %b exp 1", z); end
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL reserved wbErr got %b exp 1", e); end
    n_checks++; if (r !== 2'd3) begin n_fail++; $display("FAIL reserved wbRd got %0d exp 3", r); end
    n_checks++; if (dbg !== 8'h00) begin n_fail++; $display("FAIL reserved reg[3] got %h exp 00", dbg); end
  endtask

  task automatic test_reset_mid_op();
    int n;
    n = 0;
    while (instReady !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    instOp = 3'd2; instRd = 2'd1; instRs = 2'd0; instRt = 2'd0; instImmEn = 1'b1; instImm = 8'h33;
    instValid = 1'b1;
    @(posedge clk); #1; instValid = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (wbValid !== 1'b0) begin n_fail++; $display("FAIL rst_mid wbValid during reset got %b exp 0", wbValid); end
    @(posedge clk); #1; rst = 1'b0;
    for (int a = 0; a < 4; a++) mrf[a] = 8'h00;
    n_checks++; if (instReady !== 1'b1) begin n_fail++; $display("FAIL rst_mid instReady got %b exp 1", instReady); end
    for (int a = 0; a < 4; a++) begin
      dbgAddr = 2'(a); #1;
      n_checks++; if (dbgData !== 8'h00) begin n_fail++; $display("FAIL rst_mid reg[%0d] got %h exp 00", a, dbgData); end
    end
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++; if (wbValid !== 1'b0) begin n_fail++; $display("FAIL rst_mid stray wbValid got %b exp 0", wbValid); end
    end
  endtask

  task automatic test_random();
    logic [2:0] ops [8];
    logic [2:0] op; logic [1:0] rd, rs, rt; logic ie; logic [7:0] imm, ex, a_exp;
    logic [7:0] d, dbg; logic z, e, err; logic [1:0] r; int lat; int gap;
    ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7, 3'd4, 3'd5, 3'd6};
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 7)];
      rd = 2'($urandom_range(0, 3)); rs = 2'($urandom_range(0, 3)); rt = 2'($urandom_range(0, 3));
      ie = 1'($urandom_range(0, 1)); imm = 8'($urandom);
      a_exp = mrf[rs];
      ex  = ref_alu(op, int'(mrf[rs]), ie ? int'(imm) : int'(mrf[rt]));
      err = (op >= 3'd4 && op <= 3'd6);
      run_inst(op, rd, rs, rt, ie, imm, d, z, r, e, dbg, lat);
      mrf[rd] = ex;
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rand[%0d] latency got %0d exp 3", i, lat); end
      n_checks++; if (d !== ex) begin n_fail++; $display("FAIL rand[%0d] op%0d wbData got %h exp %h", i, op, d, ex); end
      n_checks++; if (z !== (ex == 8'h00)) begin n_fail++; $display("FAIL rand[%0d] wbZero got %b exp %b", i, z, ex == 8'h00); end
      n_checks++; if (r !== rd) begin n_fail++; $display("FAIL rand[%0d] wbRd got %0d exp %0d", i, r, rd); end
      n_checks++; if (e !== err) begin n_fail++; $display("FAIL rand[%0d] wbErr got %b exp %b", i, e, err); end
      n_checks++; if (dbg !== ex) begin n_fail++; $display("FAIL rand[%0d] dbgData got %h exp %h", i, dbg, ex); end
      n_checks++; if (aluFunSel !== op || aluA !== a_exp) begin n_fail++; $display("FAIL rand[%0d] alu drive got %0d/%h exp %0d/%h", i, aluFunSel, aluA, op, a_exp); end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        n_checks++; if (wbValid !== 1'b0 || wbData !== ex) begin n_fail++; $display("FAIL rand[%0d] wb hold got %b/%h exp 0/%h", i, wbValid, wbData, ex); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    instValid = 1'b0; instOp = 3'd0; instRd = 2'd0; instRs = 2'd0; instRt = 2'd0;
    instImmEn = 1'b0; instImm = 8'h00; dbgAddr = 2'd0; rst = 1'b1;
    test_reset();
    test_imm_add();
    test_reg_ops();
    test_back_to_back();
    test_reserved();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
